gj_axis_uart_rx: RTL and testbench

- UART receiver for the gjAxisUart family.
- Consumes the 16x-oversample enable produced by the baud-rate generator, detects and validates each frame (1 start bit, DATA_BITS data bits LSB-first, 1 stop bit, no parity), and presents each received word on an AXI-Stream master port.
- Sits between the rxd pad and the user AXIS sink; it is the receive-side counterpart to the TX path that uses the 1x bit enable.

---
 rtl/gj_axis_uart_pkg.sv | 17 +
 rtl/gj_uart_sync_maj.sv | 32 +++
 rtl/gj_axis_uart_rx.sv | 121 ++++++++++++
 tb/tb_gj_axis_uart_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gj_axis_uart_pkg.sv
// Shared types and constants for the gjAxisUart receive path.
// Ticks are 16x-oversample enables; a bit lasts OVERSAMPLE ticks.
package gj_axis_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    localparam int OVERSAMPLE    = 16;
    localparam int MID_START     = 8;
    localparam int BIT_LAST_TICK = 15;

endpackage

// File: rtl/gj_uart_sync_maj.sv
// rxd metastability synchronizer plus a 3-tap sample history with majority vote.
// The history only advances on oversample ticks; the synchronizer runs every clk.
module gj_uart_sync_maj #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_rxd,
    output logic o_rxs,
    output logic o_maj
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_hist;

    // Both chains reset to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_hist <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rxd};
            if (i_en)
                r_hist <= {r_hist[1:0], r_sync[SYNC_STAGES-1]};
        end
    end

    assign o_rxs = r_sync[SYNC_STAGES-1];
    assign o_maj = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);

endmodule

// File: rtl/gj_axis_uart_rx.sv
// 16x-oversampling UART receiver (8N1-style, DATA_BITS wide) with an AXI-Stream master output.
// One holding register: a word completing while it is still occupied is dropped and flagged.
module gj_axis_uart_rx
    import gj_axis_uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_enX16,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int BW = $clog2(DATA_BITS);

    logic                 w_rxs;
    logic                 w_maj;
    state_t               r_state;
    logic [3:0]           r_tick;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_tdata;
    logic                 r_tvalid;
    logic                 r_ferr;
    logic                 r_ovr;

    gj_uart_sync_maj #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (clk_enX16),
        .i_rxd (rxd),
        .o_rxs (w_rxs),
        .o_maj (w_maj)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_tick   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_ferr   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
            if (r_tvalid && m_axis_tready)
                r_tvalid <= 1'b0;

            if (clk_enX16) begin
                case (r_state)
                    IDLE: begin
                        if (!w_rxs) begin
                            r_tick  <= '0;
                            r_state <= START;
                        end
                    end
                    START: begin
                        r_tick <= r_tick + 4'd1;
                        // Mid start bit: a high majority means the edge was noise.
                        if (r_tick == 4'(MID_START - 1)) begin
                            if (w_maj) begin
                                r_state <= IDLE;
                            end else begin
                                r_tick  <= '0;
                                r_bit   <= '0;
                                r_state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        r_tick <= r_tick + 4'd1;
                        if (r_tick == 4'(BIT_LAST_TICK)) begin
                            r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                            r_bit   <= r_bit + BW'(1);
                            if (r_bit == BW'(DATA_BITS - 1))
                                r_state <= STOP;
                        end
                    end
                    STOP: begin
                        r_tick <= r_tick + 4'd1;
                        if (r_tick == 4'(BIT_LAST_TICK)) begin
                            if (!w_maj) begin
                                r_ferr  <= 1'b1;
                                r_state <= WAIT_IDLE;
                            end else begin
                                // Leaving at mid stop bit lets a back-to-back start edge be caught.
                                r_state <= IDLE;
                                if (r_tvalid && !m_axis_tready) begin
                                    r_ovr <= 1'b1;
                                end else begin
                                    r_tdata  <= r_shift;
                                    r_tvalid <= 1'b1;
                                end
                            end
                        end
                    end
                    WAIT_IDLE: begin
                        if (w_maj)
                            r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign frame_err     = r_ferr;
    assign overrun       = r_ovr;

endmodule

// File: tb/tb_gj_axis_uart_rx.sv
// Self-checking bench for gj_axis_uart_rx: vector table, hand-written corner sequences,
// and a random frame stream compared against a frame-level reference model.
module tb_gj_axis_uart_rx;

    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] tx;
        bit            stop_ok;
        int            exp_beats;
        logic [DW-1:0] exp_data;
        int            exp_ferr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clk_enX16 = 1'b0;
    logic          rxd = 1'b1;
    logic          m_axis_tready = 1'b1;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          frame_err;
    logic          overrun;

    int            n_chk = 0;
    int            n_fail = 0;
    int            n_ferr = 0;
    int            n_ovr = 0;
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];
    logic [1:0]    div_cnt = '0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    gj_axis_uart_rx #(.DATA_BITS(DW), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_enX16     (clk_enX16),
        .rxd           (rxd),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .frame_err     (frame_err),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // One oversample tick every 4 clk.
    always @(posedge clk) begin
        div_cnt   <= div_cnt + 2'd1;
        clk_enX16 <= (div_cnt == 2'd3);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: beats, pulses, tdata stability and pulse exclusivity.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err || overrun)
                check("ferr_ovr_exclusive", {31'b0, frame_err & overrun}, 32'd0);
            if (prev_hold)
                check("tdata_stable", {24'b0, m_axis_tdata}, {24'b0, prev_data});
            if (frame_err) n_ferr++;
            if (overrun)   n_ovr++;
            if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
            prev_hold <= m_axis_tvalid && !m_axis_tready;
            prev_data <= m_axis_tdata;
        end else begin
            prev_hold <= 1'b0;
        end
    end

    // Inputs change 2 time units after a rising edge, well clear of the sampling edge.
    task automatic wait_ticks(input int n);
        repeat (n * 4) @(posedge clk);
        #2;
    endtask

    // Frame on the line: start, DATA LSB first, stop held for stop_ticks.
    // g_bit/g_tick invert one tick of one data bit (g_bit < 0: no glitch).
    task automatic send_frame(input logic [DW-1:0] d, input bit stop_v, input int stop_ticks,
                              input int g_bit, input int g_tick);
        logic [DW+1:0] bits;
        bits = {stop_v, d, 1'b0};
        for (int b = 0; b < DW + 1; b++) begin
            for (int t = 0; t < 16; t++) begin
                rxd = bits[b] ^ ((b - 1 == g_bit && t == g_tick) ? 1'b1 : 1'b0);
                wait_ticks(1);
            end
        end
        rxd = stop_v;
        wait_ticks(stop_ticks);
        rxd = 1'b1;
    endtask

    initial begin
        vec_t          vt[5];
        int            b0, f0, o0, gap, nexp_ferr;
        logic [DW-1:0] d;
        bit            ok;

        vt[0] = '{8'h55, 1'b1, 1, 8'h55, 0};
        vt[1] = '{8'hA3, 1'b0, 0, 8'h00, 1};
        vt[2] = '{8'h3C, 1'b1, 1, 8'h3C, 0};
        vt[3] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vt[4] = '{8'h80, 1'b1, 1, 8'h80, 0};

        repeat (3) @(posedge clk);
        #2;
        check("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        check("rst_tdata",  {24'b0, m_axis_tdata},  32'd0);
        check("rst_ferr",   {31'b0, frame_err},     32'd0);
        check("rst_ovr",    {31'b0, overrun},       32'd0);
        rst_n = 1'b1;
        wait_ticks(4);

        // Vector table; the bad-stop frame holds stop low for two bit times.
        for (int i = 0; i < 5; i++) begin
            b0 = got_q.size(); f0 = n_ferr; o0 = n_ovr;
            send_frame(vt[i].tx, vt[i].stop_ok, vt[i].stop_ok ? 16 : 32, -1, 0);
            wait_ticks(24);
            check($sformatf("vec%0d_beats", i), got_q.size() - b0, vt[i].exp_beats);
            check($sformatf("vec%0d_ferr", i), n_ferr - f0, vt[i].exp_ferr);
            check($sformatf("vec%0d_ovr", i), n_ovr - o0, 0);
            if (vt[i].exp_beats == 1 && got_q.size() > b0)
                check($sformatf("vec%0d_data", i), {24'b0, got_q[b0]}, {24'b0, vt[i].exp_data});
        end

        // False start: 4 ticks low, then a real frame must still be received.
        b0 = got_q.size(); f0 = n_ferr; o0 = n_ovr;
        rxd = 1'b0; wait_ticks(4); rxd = 1'b1; wait_ticks(40);
        check("fstart_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        check("fstart_beats", got_q.size() - b0, 0);
        check("fstart_pulses", (n_ferr - f0) + (n_ovr - o0), 0);
        send_frame(8'h96, 1'b1, 16, -1, 0); wait_ticks(24);
        check("fstart_next_beats", got_q.size() - b0, 1);
        if (got_q.size() > b0) check("fstart_next_data", {24'b0, got_q[b0]}, 32'h96);

        // Single-tick glitches inside 0x00 frames, one at tick 14 and one near mid bit.
        b0 = got_q.size();
        send_frame(8'h00, 1'b1, 16, 3, 14); wait_ticks(24);
        send_frame(8'h00, 1'b1, 16, 5, 6);  wait_ticks(24);
        check("glitch_beats", got_q.size() - b0, 2);
        if (got_q.size() == b0 + 2) begin
            check("glitch14_data", {24'b0, got_q[b0]},     32'h00);
            check("glitch6_data",  {24'b0, got_q[b0 + 1]}, 32'h00);
        end

        // Overrun: held 0x11 survives, 0x22 is dropped with one pulse.
        b0 = got_q.size(); f0 = n_ferr; o0 = n_ovr;
        m_axis_tready = 1'b0;
        send_frame(8'h11, 1'b1, 16, -1, 0); wait_ticks(20);
        check("ovr_hold_tvalid", {31'b0, m_axis_tvalid}, 32'd1);
        check("ovr_hold_tdata", {24'b0, m_axis_tdata}, 32'h11);
        send_frame(8'h22, 1'b1, 16, -1, 0); wait_ticks(20);
        check("ovr_pulses", n_ovr - o0, 1);
        check("ovr_ferr", n_ferr - f0, 0);
        check("ovr_tdata", {24'b0, m_axis_tdata}, 32'h11);
        m_axis_tready = 1'b1;
        wait_ticks(10);
        check("ovr_beats", got_q.size() - b0, 1);
        if (got_q.size() > b0) check("ovr_beat_data", {24'b0, got_q[b0]}, 32'h11);

        // Reset mid-frame: a pending word and the partial 0xFF frame are both discarded.
        b0 = got_q.size(); f0 = n_ferr; o0 = n_ovr;
        m_axis_tready = 1'b0;
        send_frame(8'h5A, 1'b1, 16, -1, 0); wait_ticks(8);
        fork
            send_frame(8'hFF, 1'b1, 16, -1, 0);
            begin
                wait_ticks(16 + 5 * 16 + 8);
                rst_n = 1'b0;
                #1;
                check("midrst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
                check("midrst_tdata",  {24'b0, m_axis_tdata},  32'd0);
                check("midrst_pulses", {30'b0, frame_err, overrun}, 32'd0);
                repeat (3) @(posedge clk);
                #2;
                rst_n = 1'b1;
            end
        join
        wait_ticks(8);
        m_axis_tready = 1'b1;
        send_frame(8'h81, 1'b1, 16, -1, 0); wait_ticks(24);
        check("midrst_beats", got_q.size() - b0, 1);
        if (got_q.size() > b0) check("midrst_data", {24'b0, got_q[b0]}, 32'h81);
        check("midrst_no_pulse", (n_ferr - f0) + (n_ovr - o0), 0);

        // Random stream: model keeps every frame whose stop bit is high, counts the others.
        got_q.delete();
        exp_q.delete();
        f0 = n_ferr;
        nexp_ferr = 0;
        for (int i = 0; i < 30; i++) begin
            d   = DW'($urandom);
            ok  = ($urandom_range(0, 5) != 0);
            gap = ok ? $urandom_range(0, 10) : $urandom_range(6, 12);
            send_frame(d, ok, 16, -1, 0);
            if (ok) exp_q.push_back(d);
            else    nexp_ferr++;
            wait_ticks(gap);
        end
        wait_ticks(30);
        check("rand_count", got_q.size(), exp_q.size());
        check("rand_ferr", n_ferr - f0, nexp_ferr);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rand_word%0d", i), {24'b0, got_q[i]}, {24'b0, exp_q[i]});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
